// File: rtl/sim_serial_out_capture.sv
// sim_serial_out_capture
//   Clocked simulation model of CHANNELS independent chains of CHIPS_PER_CH
//   cascaded 74lv595 shift/storage registers. Captures the panel serial bus
//   into parallel words and adds frame-length checking, frame counting and a
//   bus-idle indicator.
//
//   Optional build macro: SERIAL_CAPTURE_CHANGE_EN
//     defined   -> frame_changed pulses with frame_valid when the latched
//                  word differs from the previously latched word
//     undefined -> frame_changed is tied low
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   ser_srclk     shift clock (synchronous to clk)
//   ser_rclk      storage/latch clock (synchronous to clk)
//   ser_data      one serial data bit per chain
//   par_data      latched words, chain c at [c*W +: W], W = 8*CHIPS_PER_CH
//   frame_valid   one-cycle pulse when par_data updates
//   frame_err     pulse with frame_valid when the frame had != W shifts
//   frame_count   latch events since reset (wraps)
//   shift_count   srclk rises since the last latch (saturates at 255)
//   idle          no rclk rise for IDLE_CYCLES clk cycles
//   frame_changed change pulse (see macro above)
module sim_serial_out_capture #(
  parameter int CHANNELS     = 4,
  parameter int CHIPS_PER_CH = 2,
  parameter int IDLE_CYCLES  = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ser_srclk,
  input  logic                               ser_rclk,
  input  logic [CHANNELS-1:0]                ser_data,
  output logic [CHANNELS*8*CHIPS_PER_CH-1:0] par_data,
  output logic                               frame_valid,
  output logic                               frame_err,
  output logic [15:0]                        frame_count,
  output logic [7:0]                         shift_count,
  output logic                               idle,
  output logic                               frame_changed
);

  localparam int          W        = 8 * CHIPS_PER_CH;
  localparam logic [15:0] IDLE_MAX = 16'(IDLE_CYCLES);

  logic                              s_srclk, s_srclk_d;
  logic                              s_rclk, s_rclk_d;
  logic [CHANNELS-1:0]               s_data;
  logic                              rise_sr, rise_rc;
  logic [CHANNELS-1:0][W-1:0]        sr;
  logic [CHANNELS-1:0][W-1:0]        par_q;
  logic [15:0]                       idle_cnt;

  // Input sampling; the delayed copies start at 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_srclk   <= 1'b0;
      s_srclk_d <= 1'b0;
      s_rclk    <= 1'b0;
      s_rclk_d  <= 1'b0;
      s_data    <= '0;
    end else begin
      s_srclk   <= ser_srclk;
      s_srclk_d <= s_srclk;
      s_rclk    <= ser_rclk;
      s_rclk_d  <= s_rclk;
      s_data    <= ser_data;
    end
  end

  always_comb begin
    rise_sr = s_srclk & ~s_srclk_d;
    rise_rc = s_rclk & ~s_rclk_d;
  end

  // Shift registers: newest bit enters at bit 0 (QA side of the cascade).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (rise_sr) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        sr[c] <= {sr[c][W-2:0], s_data[c]};
      end
    end
  end

  // Storage stage. On a tied srclk/rclk rise the latch takes the pre-shift
  // contents, which falls out of both blocks reading the same old sr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_valid <= rise_rc;
      frame_err   <= rise_rc && (int'(shift_count) != W);
      if (rise_rc) begin
        par_q       <= sr;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // A shift coinciding with a latch belongs to the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_count <= '0;
    end else if (rise_rc) begin
      shift_count <= rise_sr ? 8'd1 : 8'd0;
    end else if (rise_sr && shift_count != 8'hFF) begin
      shift_count <= shift_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (rise_rc) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign idle     = (idle_cnt == IDLE_MAX);
  assign par_data = par_q;

`ifdef SERIAL_CAPTURE_CHANGE_EN
  // par_q still holds the previous frame when the new one is latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_changed <= 1'b0;
    end else begin
      frame_changed <= rise_rc && (sr != par_q);
    end
  end
`else
  assign frame_changed = 1'b0;
`endif

endmodule
